hazard5_fetch_sram_responder: RTL and testbench
===============================================

HAZARD5_FETCH_SRAM_RESPONDER -- requirements
Module: hazard5_fetch_sram_responder

Interface
REQ-001 SHALL have parameter W_ADDR, default 32, fetch address width; other values unsupported.
REQ-002 SHALL have parameter W_DATA, default 32, fetch data width; other values unsupported.
REQ-003 SHALL have parameter SRAM_DEPTH, default 4096, SRAM size in 32-bit words; power of 2.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of SRAM word 0; aligned to SRAM_DEPTH*4.
REQ-005 SHALL have parameter WAIT_STATES, default 0, extra data-phase cycles per access; legal range 0..7.
REQ-006 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port mem_size  input  1  1 = 32-bit fetch, 0 = 16-bit fetch.
REQ-009 SHALL have port mem_addr  input  W_ADDR  fetch byte address.
REQ-010 SHALL have port mem_addr_vld  input  1  fetch request valid.
REQ-011 SHALL have port mem_addr_rdy  output  1  request accepted this cycle if mem_addr_vld.
REQ-012 SHALL have port mem_data  output  W_DATA  fetch response data.
REQ-013 SHALL have port mem_data_vld  output  1  mem_data valid this cycle.
REQ-014 SHALL have port mem_err  output  1  response carries a fault; only meaningful with mem_data_vld.
REQ-015 SHALL have port sram_addr  output  log2(SRAM_DEPTH)  SRAM word index.
REQ-016 SHALL have port sram_ren  output  1  SRAM read enable.
REQ-017 SHALL have port sram_rdata  input  32  SRAM read data, valid the cycle after sram_ren.

Function
REQ-018 SHALL model a two-stage pipeline: address phase (accept) and data phase (wait, then respond); at most one data phase in flight.
REQ-019 SHALL accept a request in a cycle where mem_addr_vld && mem_addr_rdy.
REQ-020 SHALL drive mem_addr_rdy = !dph_valid || (wait_ctr == 0). It is a function of registered state only, with no combinational path from mem_addr_vld.
REQ-021 On accept, SHALL register addr word index, fault flag and dph_valid=1, and SHALL load wait_ctr = WAIT_STATES.
REQ-022 While dph_valid && wait_ctr != 0, SHALL decrement wait_ctr by 1 per cycle.
REQ-023 SHALL drive mem_data_vld = dph_valid && (wait_ctr == 0); an access accepted in cycle N responds in cycle N+1+WAIT_STATES.
REQ-024 SHALL clear dph_valid after the response cycle unless a new request is accepted in that same cycle; this allows back-to-back acceptance.
REQ-025 With WAIT_STATES=0 and mem_addr_vld held high, SHALL sustain one accept and one response per cycle.
REQ-026 SHALL issue exactly one sram_ren per non-faulting access, in the cycle before its response cycle.
REQ-027 When WAIT_STATES=0, SHALL drive sram_addr from live mem_addr[2 +: log2(SRAM_DEPTH)]; otherwise SHALL drive sram_addr from the registered index.
REQ-028 SHALL drive mem_data = sram_rdata unmodified in the response cycle for all sizes. A 16-bit fetch at addr[1]=1 returns its halfword in bits 31:16, and a 16-bit fetch at addr[1]=0 returns it in bits 15:0.
REQ-029 SHALL ignore mem_addr[1:0] for SRAM indexing.
REQ-030 SHALL flag fault at accept if the address is outside [BASE_ADDR, BASE_ADDR+4*SRAM_DEPTH), or if mem_size=1 and addr[1:0]!=0, or if mem_size=0 and addr[0]=1.
REQ-031 A faulting access SHALL still respond after the same latency with mem_err=1 and mem_data=0, and SHALL NOT assert sram_ren.
REQ-032 SHALL drive mem_err=0 and mem_data=0 whenever mem_data_vld=0.
REQ-033 SHALL ignore mem_addr and mem_size changes while mem_addr_rdy=0. Requesters hold them stable, and they are sampled only at accept.
REQ-034 SHALL return responses strictly in acceptance order, exactly one response per accept, never unsolicited.

Reset
REQ-035 On rst=1, SHALL immediately clear dph_valid, wait_ctr and the fault flag.
REQ-036 While rst=1, SHALL hold mem_addr_rdy=1, mem_data_vld=0, mem_err=0, mem_data=0 and sram_ren=0.
REQ-037 Reset during a data phase SHALL discard that access, with no response produced after reset release.
REQ-038 The first accept SHALL be possible in the first clock edge after rst deasserts.

Verification
REQ-039 With WAIT_STATES=0, continuous 32-bit fetches at 0x0,0x4,0x8 -> mem_data_vld high cycles 1,2,3; data = SRAM words 0,1,2; mem_addr_rdy constantly 1.
REQ-040 With WAIT_STATES=2, fetch 0x10 accepted cycle 0, second request pending -> response cycle 3; mem_addr_rdy low cycles 1-2, high cycle 3; second request responds cycle 6.
REQ-041 16-bit fetch at 0x6 -> mem_data = SRAM word 1 in full, mem_err=0; 16-bit fetch at 0x5 -> mem_err=1, mem_data=0, no sram_ren.
REQ-042 32-bit fetch at BASE_ADDR+4*SRAM_DEPTH -> response at normal latency with mem_err=1 and mem_data=0; a following in-range fetch returns correct data with mem_err=0.
REQ-043 With WAIT_STATES=3, assert rst one cycle after accept -> mem_data_vld never asserts for that access; post-reset fetch of 0x0 responds correctly at cycle 4 after its accept.
REQ-044 Randomised mem_addr_vld with changing addr while rdy=0 -> scoreboard shows in-order responses, one per accept, data matching the address captured at accept.

Source files
------------

// File: rtl/hazard5_fetch_sram_responder.sv
// Hazard5 instruction-fetch port responder backed by a single-port SRAM.
// Two-stage pipeline: the address phase accepts a request, and the data phase
// waits WAIT_STATES cycles and then returns the SRAM word (or a fault).
// At most one data phase is in flight at a time.
//
// Handshake: a request transfers on a rising edge where mem_addr_vld && mem_addr_rdy.
// mem_addr_rdy depends only on registered state. mem_addr/mem_size are sampled
// only at that edge. Each accept produces exactly one response. The response is a
// single cycle with mem_data_vld=1, returned in acceptance order. mem_data and
// mem_err are held at zero in every other cycle.
module hazard5_fetch_sram_responder #(
    parameter int                W_ADDR      = 32,
    parameter int                W_DATA      = 32,
    parameter int                SRAM_DEPTH  = 4096,
    parameter logic [W_ADDR-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mem_size,
    input  logic [W_ADDR-1:0]             mem_addr,
    input  logic                          mem_addr_vld,
    output logic                          mem_addr_rdy,
    output logic [W_DATA-1:0]             mem_data,
    output logic                          mem_data_vld,
    output logic                          mem_err,
    output logic [$clog2(SRAM_DEPTH)-1:0] sram_addr,
    output logic                          sram_ren,
    input  logic [31:0]                   sram_rdata
);

    localparam int         W_IDX   = $clog2(SRAM_DEPTH);
    localparam logic [2:0] WAIT_LD = 3'(WAIT_STATES);

    // Data-phase state
    logic             dph_valid;
    logic [2:0]       wait_ctr;
    logic             dph_fault;

    // Address-phase decode
    logic             accept;
    logic             in_range;
    logic             misaligned;
    logic             req_fault;
    logic [W_IDX-1:0] req_idx;

    // The SRAM window is aligned to its own size, so a range check is an equality
    // test on the address bits above the word index.
    assign req_idx    = mem_addr[2 +: W_IDX];
    assign in_range   = (mem_addr[W_ADDR-1:W_IDX+2] == BASE_ADDR[W_ADDR-1:W_IDX+2]);
    assign misaligned = mem_size ? (mem_addr[1:0] != 2'b00) : mem_addr[0];
    assign req_fault  = !in_range || misaligned;

    // A new request is taken whenever the data phase is empty or is responding now.
    assign mem_addr_rdy = !dph_valid || (wait_ctr == 3'd0);
    assign accept       = mem_addr_vld && mem_addr_rdy && !rst;

    // The response cycle is the last cycle of the data phase.
    assign mem_data_vld = dph_valid && (wait_ctr == 3'd0);
    assign mem_err      = mem_data_vld && dph_fault;
    assign mem_data     = (mem_data_vld && !dph_fault) ? sram_rdata : 32'h0;

    // Data-phase sequencing: load on accept, count down wait states, retire after response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dph_valid <= 1'b0;
            wait_ctr  <= 3'd0;
            dph_fault <= 1'b0;
        end else if (accept) begin
            dph_valid <= 1'b1;
            wait_ctr  <= WAIT_LD;
            dph_fault <= req_fault;
        end else if (dph_valid) begin
            if (wait_ctr != 3'd0) begin
                wait_ctr <= wait_ctr - 3'd1;
            end else begin
                dph_valid <= 1'b0;
            end
        end
    end

    // The SRAM read has to land one cycle before the response. With no wait states,
    // that is the accept cycle itself, so the read uses the live address. Otherwise
    // it uses the index captured at accept.
    if (WAIT_STATES == 0) begin : g_no_wait
        assign sram_addr = req_idx;
        assign sram_ren  = accept && !req_fault;
    end else begin : g_wait
        logic [W_IDX-1:0] dph_idx;

        // Capture the word index of the accepted request
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dph_idx <= '0;
            end else if (accept) begin
                dph_idx <= req_idx;
            end
        end

        assign sram_addr = dph_idx;
        assign sram_ren  = dph_valid && (wait_ctr == 3'd1) && !dph_fault && !rst;
    end

endmodule

// File: tb/tb_hazard5_fetch_sram_responder.sv
// Bench for hazard5_fetch_sram_responder: three instances (0, 2 and 3 wait states)
// share clock, reset and stimulus style; a queue-based reference model predicts
// every output of every instance each cycle.
module tb_hazard5_fetch_sram_responder;

    localparam int          ND   = 3;
    localparam int          D    = 64;
    localparam int          IW   = 6;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_size     [ND];
    logic [31:0]   mem_addr     [ND];
    logic          mem_addr_vld [ND];
    logic          mem_addr_rdy [ND];
    logic [31:0]   mem_data     [ND];
    logic          mem_data_vld [ND];
    logic          mem_err      [ND];
    logic [IW-1:0] sram_addr    [ND];
    logic          sram_ren     [ND];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Scoreboard entries: {err, due cycle[31:0], word index[31:0]}
    logic [64:0] exp_q       [ND][$];
    int          resp_cyc_q  [ND][$];
    logic        acc         [ND];
    logic        last_err    [ND];
    logic [31:0] last_data   [ND];
    int          resp_n      [ND];

    typedef struct {
        logic size;
        int   off;
        logic err;
        int   idx;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] idx);
        return {~idx[15:0], idx[15:0]} ^ 32'h1234_5678;
    endfunction

    function automatic logic fault_of(input logic size, input logic [31:0] addr);
        logic oor;
        logic mis;
        oor = (addr < BASE) || (addr >= BASE + 32'(4 * D));
        mis = size ? (addr[1:0] != 2'b00) : addr[0];
        return oor || mis;
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        logic [31:0] rdata;

        hazard5_fetch_sram_responder #(
            .W_ADDR(32), .W_DATA(32), .SRAM_DEPTH(D), .BASE_ADDR(BASE),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) dut (
            .clk(clk), .rst(rst),
            .mem_size(mem_size[g]), .mem_addr(mem_addr[g]),
            .mem_addr_vld(mem_addr_vld[g]), .mem_addr_rdy(mem_addr_rdy[g]),
            .mem_data(mem_data[g]), .mem_data_vld(mem_data_vld[g]), .mem_err(mem_err[g]),
            .sram_addr(sram_addr[g]), .sram_ren(sram_ren[g]), .sram_rdata(rdata)
        );

        // SRAM: known contents on a read, junk otherwise so a missing read shows up
        always @(posedge clk) begin
            if (sram_ren[g]) rdata <= word_of(32'(sram_addr[g]));
            else             rdata <= 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    // One clock: check all outputs at the falling edge, advance the model, return just after the rising edge
    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            logic [64:0] head;
            logic        has_head, exp_vld, exp_rdy, exp_err, exp_ren, f;
            logic [31:0] exp_data, exp_sidx, idx;
            if (rst) exp_q[k].delete();
            has_head = exp_q[k].size() > 0;
            head     = has_head ? exp_q[k][0] : 65'h0;
            exp_vld  = has_head && (head[63:32] == 32'(cyc));
            exp_rdy  = !has_head || exp_vld;
            exp_err  = exp_vld && head[64];
            exp_data = (exp_vld && !head[64]) ? word_of(head[31:0]) : 32'h0;
            acc[k]   = !rst && mem_addr_vld[k] && exp_rdy;
            f        = fault_of(mem_size[k], mem_addr[k]);
            idx      = (mem_addr[k] - BASE) >> 2;
            exp_ren  = 1'b0;
            exp_sidx = 32'h0;
            if (has_head && !head[64] && head[63:32] == 32'(cyc + 1)) begin
                exp_ren  = 1'b1;
                exp_sidx = head[31:0];
            end
            if (acc[k] && !f && ws_of(k) == 0) begin
                exp_ren  = 1'b1;
                exp_sidx = idx;
            end
            chk("rdy",  k, 32'(mem_addr_rdy[k]), 32'(exp_rdy));
            chk("vld",  k, 32'(mem_data_vld[k]), 32'(exp_vld));
            chk("err",  k, 32'(mem_err[k]),      32'(exp_err));
            chk("data", k, mem_data[k],          exp_data);
            chk("ren",  k, 32'(sram_ren[k]),     32'(exp_ren));
            if (exp_ren) chk("sram_addr", k, 32'(sram_addr[k]), exp_sidx);
            if (mem_data_vld[k]) begin
                resp_n[k]++;
                last_err[k]  = mem_err[k];
                last_data[k] = mem_data[k];
                resp_cyc_q[k].push_back(cyc);
            end
            if (exp_vld) void'(exp_q[k].pop_front());
            if (acc[k]) exp_q[k].push_back({f, 32'(cyc + 1 + ws_of(k)), idx});
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < ND; k++) mem_addr_vld[k] = 1'b0;
    endtask

    // Three back-to-back 32-bit fetches, each held until accepted
    task automatic run_list(input logic [31:0] a0);
        int ptr[ND];
        int c0;
        c0 = cyc;
        for (int k = 0; k < ND; k++) begin
            ptr[k] = 0;
            resp_cyc_q[k].delete();
        end
        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < ND; k++) begin
                mem_size[k]     = 1'b1;
                mem_addr[k]     = BASE + a0 + 32'(4 * ptr[k]);
                mem_addr_vld[k] = (ptr[k] < 3);
            end
            cycle();
            for (int k = 0; k < ND; k++) if (acc[k]) ptr[k]++;
        end
        idle_all();
        for (int k = 0; k < ND; k++) begin
            chk("list_count", k, 32'(resp_cyc_q[k].size()), 32'd3);
            for (int i = 0; i < 3; i++)
                if (i < resp_cyc_q[k].size())
                    chk("list_resp_cyc", k, 32'(resp_cyc_q[k][i]), 32'(c0 + (i + 1) * (1 + ws_of(k))));
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 0,         1'b0, 0};
        vecs[1]  = '{1'b1, 4,         1'b0, 1};
        vecs[2]  = '{1'b0, 6,         1'b0, 1};
        vecs[3]  = '{1'b0, 4,         1'b0, 1};
        vecs[4]  = '{1'b0, 5,         1'b1, 0};
        vecs[5]  = '{1'b1, 2,         1'b1, 0};
        vecs[6]  = '{1'b1, 1,         1'b1, 0};
        vecs[7]  = '{1'b1, 4 * D - 4, 1'b0, D - 1};
        vecs[8]  = '{1'b1, 4 * D,     1'b1, 0};
        vecs[9]  = '{1'b1, 8,         1'b0, 2};
        vecs[10] = '{1'b1, -4,        1'b1, 0};
        vecs[11] = '{1'b0, 4 * D - 2, 1'b0, D - 1};

        rst = 1'b1;
        for (int k = 0; k < ND; k++) begin
            mem_size[k] = 1'b0; mem_addr[k] = 32'h0; mem_addr_vld[k] = 1'b0; resp_n[k] = 0;
        end
        repeat (2) cycle();
        // Request pending during reset must not be taken
        for (int k = 0; k < ND; k++) begin
            mem_size[k] = 1'b1; mem_addr[k] = BASE; mem_addr_vld[k] = 1'b1;
        end
        cycle();
        rst = 1'b0;
        idle_all();
        repeat (2) cycle();

        // Single isolated fetches against fixed expectations
        foreach (vecs[v]) begin
            int base_n[ND];
            for (int k = 0; k < ND; k++) begin
                base_n[k]       = resp_n[k];
                mem_size[k]     = vecs[v].size;
                mem_addr[k]     = 32'(int'(BASE) + vecs[v].off);
                mem_addr_vld[k] = 1'b1;
            end
            cycle();
            idle_all();
            repeat (5) cycle();
            for (int k = 0; k < ND; k++) begin
                chk("vec_count", k, 32'(resp_n[k] - base_n[k]), 32'd1);
                chk("vec_err",   k, 32'(last_err[k]), 32'(vecs[v].err));
                chk("vec_data",  k, last_data[k], vecs[v].err ? 32'h0 : word_of(32'(vecs[v].idx)));
            end
        end

        run_list(32'h0);
        run_list(32'h10);

        // Reset one cycle after accept: the access vanishes; the next fetch is normal
        for (int k = 0; k < ND; k++) begin
            mem_size[k] = 1'b1; mem_addr[k] = BASE + 32'h20; mem_addr_vld[k] = 1'b1;
        end
        cycle();
        idle_all();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        begin
            int c1;
            c1 = cyc;
            for (int k = 0; k < ND; k++) begin
                resp_cyc_q[k].delete();
                mem_addr[k] = BASE; mem_addr_vld[k] = 1'b1;
            end
            cycle();
            idle_all();
            repeat (8) cycle();
            for (int k = 0; k < ND; k++) begin
                chk("rst_count", k, 32'(resp_cyc_q[k].size()), 32'd1);
                if (resp_cyc_q[k].size() > 0)
                    chk("rst_resp_cyc", k, 32'(resp_cyc_q[k][0]), 32'(c1 + 1 + ws_of(k)));
                chk("rst_data", k, last_data[k], word_of(32'h0));
                chk("rst_err",  k, 32'(last_err[k]), 32'd0);
            end
        end

        // Random traffic, addresses change freely while not ready, rare resets
        for (int n = 0; n < 900; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < ND; k++) begin
                logic [31:0] a;
                mem_addr_vld[k] = ($urandom_range(0, 3) != 0);
                mem_size[k]     = 1'($urandom_range(0, 1));
                a = BASE - 32'd16 + 32'($urandom_range(0, 4 * D + 31));
                if ($urandom_range(0, 3) != 0) a = mem_size[k] ? (a & ~32'h3) : (a & ~32'h1);
                mem_addr[k] = a;
            end
            cycle();
        end
        rst = 1'b0;
        idle_all();
        repeat (6) cycle();
        for (int k = 0; k < ND; k++) chk("drain", k, 32'(exp_q[k].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
